// File: rtl/urp_pcie_rx_dll_if.sv
// Bundle of the frame, TLP, DLLP and error-pulse signals of the receive DLL.
// No latency: plain wires between the DLL and its neighbours.
// Backpressure: valid/ready on frame, TLP and DLLP channels.
interface urp_pcie_rx_dll_if;
  logic [267:0] frame_i;
  logic         frame_valid_i;
  logic         frame_ready_o;
  logic [223:0] tlp_o;
  logic         tlp_valid_o;
  logic         tlp_ready_i;
  logic [31:0]  dllp_o;
  logic         dllp_valid_o;
  logic         dllp_ready_i;
  logic         lcrc_err_o;
  logic         seq_err_o;

  // View taken by the receive DLL itself.
  modport master (
    input  frame_i, frame_valid_i, tlp_ready_i, dllp_ready_i,
    output frame_ready_o, tlp_o, tlp_valid_o, dllp_o, dllp_valid_o,
           lcrc_err_o, seq_err_o
  );

  // View taken by the surrounding link (frame source, TLP and DLLP sinks).
  modport slave (
    output frame_i, frame_valid_i, tlp_ready_i, dllp_ready_i,
    input  frame_ready_o, tlp_o, tlp_valid_o, dllp_o, dllp_valid_o,
           lcrc_err_o, seq_err_o
  );
endinterface

// File: rtl/urp_pcie_rx_dll.sv
// Receive DLL: LCRC + sequence check, forwards in-order TLPs, emits ACK/NAK DLLPs.
// Latency: one cycle from accepted frame to TLP / DLLP / error pulse.
// Backpressure: frame taken only when both the TLP and DLLP output registers can accept.
module urp_pcie_rx_dll #(
  parameter int ACK_THRESH  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  urp_pcie_rx_dll_if.master bus
);

  localparam int CNT_W = $clog2(ACK_THRESH + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_THRESH);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(ACK_TIMEOUT);
  localparam logic [7:0]       TYPE_ACK = 8'h00;
  localparam logic [7:0]       TYPE_NAK = 8'h10;

  // Bit-serial CRC-32 over {seq, TLP}, MSB first; unrolled into a parallel XOR tree.
  function automatic logic [31:0] lcrc32(input logic [235:0] data);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 235; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else                 c = {c[30:0], 1'b0};
    end
    return ~c;
  endfunction

  logic [11:0]      next_seq_q, next_seq_d;
  logic             nak_sched_q, nak_sched_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [TMR_W-1:0] ack_timer_q, ack_timer_d;
  logic [223:0]     tlp_q, tlp_d;
  logic             tlp_vld_q, tlp_vld_d;
  logic [31:0]      dllp_q, dllp_d;
  logic             dllp_vld_q, dllp_vld_d;
  logic             lcrc_err_q, lcrc_err_d;
  logic             seq_err_q, seq_err_d;

  logic [11:0]      frame_seq;
  logic [223:0]     frame_tlp;
  logic [31:0]      frame_crc;
  logic             crc_ok;
  logic [11:0]      seq_dist;
  logic             tlp_free, dllp_free, frame_rdy, accept;
  logic             is_bad, is_good, is_dup, is_ahead;
  logic             nak_req, coal_req, dllp_load;
  logic [CNT_W-1:0] cnt_upd;

  assign frame_seq = bus.frame_i[267:256];
  assign frame_tlp = bus.frame_i[255:32];
  assign frame_crc = bus.frame_i[31:0];
  assign crc_ok    = (lcrc32(bus.frame_i[267:32]) == frame_crc);
  assign seq_dist  = frame_seq - next_seq_q;

  // Handshake: a frame may only enter when both output registers drain this cycle.
  always_comb begin
    tlp_free  = !tlp_vld_q  || bus.tlp_ready_i;
    dllp_free = !dllp_vld_q || bus.dllp_ready_i;
    frame_rdy = !rst && tlp_free && dllp_free;
    accept    = bus.frame_valid_i && frame_rdy;
    is_bad    = accept && !crc_ok;
    is_good   = accept && crc_ok && (seq_dist == 12'd0);
    is_dup    = accept && crc_ok && seq_dist[11];
    is_ahead  = accept && crc_ok && (seq_dist != 12'd0) && !seq_dist[11];
    nak_req   = (is_bad || is_ahead) && !nak_sched_q;
    // A coalesced ACK waits in the counters until the DLLP register has room.
    coal_req  = (ack_cnt_q == CNT_MAX) || (ack_timer_q == TMR_MAX);
    // nak_req and is_dup imply accept, which already implies dllp_free.
    dllp_load = nak_req || is_dup || (coal_req && dllp_free);
  end

  // Next-state for sequence tracking, ACK coalescing and the output registers.
  always_comb begin
    next_seq_d  = is_good ? next_seq_q + 12'd1 : next_seq_q;
    nak_sched_d = nak_sched_q;
    if (is_good)      nak_sched_d = 1'b0;
    else if (nak_req) nak_sched_d = 1'b1;

    cnt_upd = (is_good && ack_cnt_q != CNT_MAX) ? ack_cnt_q + CNT_W'(1) : ack_cnt_q;
    if (dllp_load) begin
      ack_cnt_d   = '0;
      ack_timer_d = '0;
    end else begin
      ack_cnt_d   = cnt_upd;
      ack_timer_d = (cnt_upd != '0 && ack_timer_q != TMR_MAX) ?
                    ack_timer_q + TMR_W'(1) : ack_timer_q;
    end

    tlp_d     = tlp_q;
    tlp_vld_d = tlp_vld_q;
    if (is_good) begin
      tlp_d     = frame_tlp;
      tlp_vld_d = 1'b1;
    end else if (bus.tlp_ready_i) begin
      tlp_vld_d = 1'b0;
    end

    // NAK outranks a duplicate ACK, which outranks a coalesced ACK; a NAK
    // acknowledges up to NEXT_RCV_SEQ-1, so a coinciding coalesced ACK is dropped.
    dllp_d     = dllp_q;
    dllp_vld_d = dllp_vld_q;
    if (dllp_load) begin
      dllp_d     = {(nak_req ? TYPE_NAK : TYPE_ACK), 12'h000, next_seq_d - 12'd1};
      dllp_vld_d = 1'b1;
    end else if (bus.dllp_ready_i) begin
      dllp_vld_d = 1'b0;
    end

    lcrc_err_d = is_bad;
    seq_err_d  = is_ahead;
  end

  // State registers with synchronous reset clearing all held output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_seq_q  <= '0;
      nak_sched_q <= 1'b0;
      ack_cnt_q   <= '0;
      ack_timer_q <= '0;
      tlp_q       <= '0;
      tlp_vld_q   <= 1'b0;
      dllp_q      <= '0;
      dllp_vld_q  <= 1'b0;
      lcrc_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      next_seq_q  <= next_seq_d;
      nak_sched_q <= nak_sched_d;
      ack_cnt_q   <= ack_cnt_d;
      ack_timer_q <= ack_timer_d;
      tlp_q       <= tlp_d;
      tlp_vld_q   <= tlp_vld_d;
      dllp_q      <= dllp_d;
      dllp_vld_q  <= dllp_vld_d;
      lcrc_err_q  <= lcrc_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bus.frame_ready_o = frame_rdy;
  assign bus.tlp_o         = tlp_q;
  assign bus.tlp_valid_o   = tlp_vld_q;
  assign bus.dllp_o        = dllp_q;
  assign bus.dllp_valid_o  = dllp_vld_q;
  assign bus.lcrc_err_o    = lcrc_err_q;
  assign bus.seq_err_o     = seq_err_q;

endmodule

// File: doc/urp_pcie_rx_dll.md
# urp_pcie_rx_dll

Receive-side PCIe data link layer. It accepts 268-bit link frames from the physical-side receive path and checks their LCRC and sequence number. Valid, in-order TLPs (224 bits) go up to the RX transaction layer. The block returns ACK/NAK DLLPs (32 bits) to the peer transmit data link layer, whose `dllp_i` port consumes them.

## Interface
- `ACK_THRESH`, default 4: in-order TLPs accepted before a coalesced ACK is forced.
- `ACK_TIMEOUT`, default 64: cycles an unacknowledged accepted TLP may wait before an ACK is forced.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_i`  in  268  frame fields:
  - [267:256] sequence number.
  - [255:32] TLP.
  - [31:0] LCRC.
- `frame_valid_i`  in  1  frame present.
- `frame_ready_o`  out  1  frame accepted when high together with valid.
- `tlp_o`  out  224  TLP to the transaction layer.
- `tlp_valid_o`  out  1  TLP valid.
- `tlp_ready_i`  in  1  transaction layer accepts.
- `dllp_o`  out  32  DLLP fields:
  - [31:24] type: 0x00 ACK, 0x10 NAK.
  - [23:12] zero.
  - [11:0] AckNak_Seq_Num.
- `dllp_valid_o`  out  1  DLLP valid.
- `dllp_ready_i`  in  1  peer accepts DLLP.
- `lcrc_err_o`  out  1  one-cycle pulse on LCRC failure.
- `seq_err_o`  out  1  one-cycle pulse on out-of-order (ahead) sequence number.

## Operation
- State:
  - NEXT_RCV_SEQ (12 bits).
  - nak_sched flag.
  - ack_cnt, 0..ACK_THRESH.
  - ack_timer, 0..ACK_TIMEOUT.
  - one-entry TLP output register.
  - one-entry DLLP output register.
- LCRC check:
  - CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, result bit-inverted.
  - Computed over the 236 bits {seq, TLP}, MSB first.
  - Compared against `frame_i[31:0]`.
- d = (seq − NEXT_RCV_SEQ) mod 4096, 12-bit wrap arithmetic.
- Classification of each accepted frame, evaluated in order:
  - LCRC bad: discard; pulse `lcrc_err_o`. If nak_sched=0, queue NAK and set nak_sched.
  - d==0 (GOOD): load the TLP register; NEXT_RCV_SEQ+1 (4095→0); clear nak_sched; ack_cnt+1.
  - d≥2048 (DUPLICATE): discard; queue ACK immediately.
  - otherwise (AHEAD): discard; pulse `seq_err_o`. If nak_sched=0, queue NAK and set nak_sched.
- Coalesced ACK fires when either holds:
  - ack_cnt reaches ACK_THRESH.
  - ack_timer reaches ACK_TIMEOUT; ack_timer counts every cycle while ack_cnt>0.
- DLLP load:
  - Priority: NAK > duplicate ACK > coalesced ACK.
  - AckNak_Seq_Num = NEXT_RCV_SEQ−1 (mod 4096), using the value after the update for the current frame.
  - Any ACK or NAK load clears ack_cnt and ack_timer.
- A pending coalesced ACK with a busy DLLP register stays pending; it is loaded on the first free cycle.
- Reset mid-operation discards all held TLP/DLLP state; no partial output survives.

## Timing
- Reset values:
  - `frame_ready_o`=0 during reset.
  - `tlp_valid_o`=0, `tlp_o`=0.
  - `dllp_valid_o`=0, `dllp_o`=0.
  - `lcrc_err_o`=0, `seq_err_o`=0.
  - NEXT_RCV_SEQ=0, nak_sched=0, counters 0.
- `frame_ready_o` = !rst && (!tlp_valid_o || tlp_ready_i) && (!dllp_valid_o || dllp_ready_i).
  - Combinational; no dependence on `frame_valid_i`.
- Frame accepted at edge N:
  - GOOD TLP: `tlp_valid_o`=1 from cycle N+1. Throughput is 1 frame/cycle while both sinks are ready.
  - NAK/duplicate ACK: `dllp_valid_o`=1 from cycle N+1.
  - Error pulses: high in cycle N+1 only.
- Valid outputs hold data stable until their ready is seen; a new value may load on the same edge as the handshake.
- Simultaneous threshold ACK and NAK on one edge: NAK wins and the ACK is dropped. The NAK implicitly acknowledges through NEXT_RCV_SEQ−1.

## Test plan
- In order, ready sinks held high:
  - Stimulus: reset, then 4 good frames with seq 0,1,2,3 back-to-back.
  - Response: 4 TLPs out on consecutive cycles, then one DLLP 0x00000003.
- LCRC error and NAK suppression:
  - Stimulus: good seq 0, then seq 1 with a flipped LCRC bit, then seq 1 bad again, then seq 1 good.
  - Response: one `lcrc_err_o` pulse per bad frame; exactly one NAK 0x10000000; then seq 1 is forwarded and nak_sched clears.
- Duplicate:
  - Stimulus: after accepting seq 0..2, resend seq 1.
  - Response: TLP dropped; immediate ACK 0x00000002.
- Ahead:
  - Stimulus: after reset, send seq 5.
  - Response: `seq_err_o` pulse; NAK 0x10000FFF; nothing forwarded.
- Wrap and timeout:
  - Stimulus: preload NEXT_RCV_SEQ to 4095 via 4095 good frames; send seq 4095 then seq 0, then idle for 64 cycles.
  - Response: both TLPs forwarded; ACK 0x00000000 exactly at timeout.
- Backpressure and reset:
  - Stimulus: hold `tlp_ready_i`=0 and send 2 frames; then assert `rst` for one cycle.
  - Response: `frame_ready_o`=0 after the first frame; the second frame is not taken; after reset all outputs are 0 and NEXT_RCV_SEQ=0.
